// File: rtl/shift_operand_pipe.sv
// Two-stage valid/ready pipeline that forms the ALU second operand N from RB, the immediate and the SAR.
// Optional macro SHIFT_OVF_FLAG_EN adds out_ovf, flagging 1 bits lost by a mode-100 left shift.
module shift_operand_pipe #(
   parameter int DW  = 32,
   parameter int IW  = 21,
   parameter int SAW = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           sar_we,
   input  logic [SAW-1:0] sar_d,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  RB,
   input  logic [IW-1:0]  I,
   input  logic [2:0]     S,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  N,
   output logic [SAW-1:0] sar_q
`ifdef SHIFT_OVF_FLAG_EN
   ,
   output logic           out_ovf
`endif
);

   logic           sarValue_q;
   logic [SAW-1:0] sarReg_q;
   logic           s1Valid_q, s1Valid_d;
   logic           s2Valid_q, s2Valid_d;
   logic [DW-1:0]  s1Rb_q;
   logic [IW-1:0]  s1Imm_q;
   logic [2:0]     s1Mode_q;
   logic [SAW-1:0] s1Sh_q;
   logic [DW-1:0]  result_q, result_d;
   logic           s2Load, s1Load, accept;
   logic [5:0]     extLen;
   logic [DW-1:0]  extMask, rbShr, rbSra;

   assign s2Load    = !s2Valid_q || out_ready;
   assign s1Load    = !s1Valid_q || s2Load;
   assign accept    = in_valid && s1Load;
   assign in_ready  = s1Load;
   assign out_valid = s2Valid_q;
   assign N         = result_q;
   assign sar_q     = sarReg_q;
   assign sarValue_q = 1'b0;

   // flush overrides normal advance; an op presented in the same cycle is dropped
   always_comb begin
      s1Valid_d = s1Valid_q;
      s2Valid_d = s2Valid_q;
      if (s2Load) s2Valid_d = s1Valid_q;
      if (s1Load) s1Valid_d = in_valid;
      if (flush) begin
         s1Valid_d = 1'b0;
         s2Valid_d = 1'b0;
      end
   end

   // a field length of DW or more shifts the ones out entirely, leaving no mask
   always_comb begin
      extLen   = {1'b0, s1Imm_q[4:0]} + 6'd1;
      extMask  = ~({DW{1'b1}} << extLen);
      rbShr    = s1Rb_q >> s1Sh_q;
      rbSra    = $unsigned($signed(s1Rb_q) >>> s1Sh_q);
      result_d = s1Rb_q;
      case (s1Mode_q)
         3'b000: result_d = s1Rb_q;
         3'b001: result_d = DW'(s1Imm_q) << (DW - IW);
         3'b010: result_d = {{(DW-14){s1Imm_q[13]}}, s1Imm_q[13:0]};
         3'b011: result_d = {{(DW-5){s1Imm_q[4]}}, s1Imm_q[4:0]};
         3'b100: result_d = s1Rb_q << s1Sh_q;
         3'b101: result_d = rbShr;
         3'b110: result_d = rbSra;
         default: result_d = rbShr & extMask;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sarReg_q  <= '0;
         s1Valid_q <= 1'b0;
         s2Valid_q <= 1'b0;
         s1Rb_q    <= '0;
         s1Imm_q   <= '0;
         s1Mode_q  <= '0;
         s1Sh_q    <= '0;
         result_q  <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s2Valid_q <= s2Valid_d;
         if (sar_we) sarReg_q <= sar_d;
         // snapshot the pre-write SAR so a same-cycle sar_we only affects later ops
         if (accept) begin
            s1Rb_q   <= RB;
            s1Imm_q  <= I;
            s1Mode_q <= S;
            s1Sh_q   <= sarReg_q;
         end
         if (s2Load && s1Valid_q) result_q <= result_d;
      end
   end

`ifdef SHIFT_OVF_FLAG_EN
   logic [2*DW-1:0] wideShl;
   logic            ovf_q, ovf_d;

   always_comb begin
      wideShl = {{DW{1'b0}}, s1Rb_q} << s1Sh_q;
      ovf_d   = (s1Mode_q == 3'b100) && (|wideShl[2*DW-1:DW]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else if (s2Load && s1Valid_q) ovf_q <= ovf_d;
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shift_operand_pipe.sv
// Randomized and directed bench for shift_operand_pipe against a FIFO scoreboard of expected operands.
// Define SHIFT_OVF_FLAG_EN to also check out_ovf.
module tb_shift_operand_pipe;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        sar_we;
   logic [4:0]  sar_d;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] RB;
   logic [20:0] I;
   logic [2:0]  S;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] N;
   logic [4:0]  sar_q;
`ifdef SHIFT_OVF_FLAG_EN
   logic        out_ovf;
`endif

   typedef struct {
      logic [31:0] n;
      logic        ovf;
      int          stamp;
   } expEntry_t;

   expEntry_t   expQ[$];
   logic [4:0]  modelSar;
   logic [31:0] lastOutN;
   int          cycleNum;
   int          checkCount;
   int          failCount;

   shift_operand_pipe #(.DW(32), .IW(21), .SAW(5)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .sar_we(sar_we),
      .sar_d(sar_d),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .RB(RB),
      .I(I),
      .S(S),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .N(N),
      .sar_q(sar_q)
`ifdef SHIFT_OVF_FLAG_EN
      ,
      .out_ovf(out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
      end
   endtask

   // Operand as the mode table defines it, using plain arithmetic
   function automatic logic [31:0] modelN(input logic [31:0] rb, input logic [20:0] imm,
                                         input logic [2:0] s, input logic [4:0] sh);
      logic [31:0] immWide;
      logic [63:0] field;
      int          len;
      immWide = {11'b0, imm};
      case (s)
         3'd0: return rb;
         3'd1: return immWide * 32'd2048;
         3'd2: return imm[13] ? (32'hFFFFC000 | {18'b0, imm[13:0]}) : {18'b0, imm[13:0]};
         3'd3: return imm[4] ? (32'hFFFFFFE0 | {27'b0, imm[4:0]}) : {27'b0, imm[4:0]};
         3'd4: return rb << sh;
         3'd5: return rb >> sh;
         3'd6: return rb[31] ? ((rb >> sh) | ~(32'hFFFFFFFF >> sh)) : (rb >> sh);
         default: begin
            len = int'(imm[4:0]) + 1;
            if (len >= 32) return rb >> sh;
            field = {32'b0, rb >> sh} % (64'd1 << len);
            return field[31:0];
         end
      endcase
   endfunction

   function automatic logic modelOvf(input logic [31:0] rb, input logic [2:0] s, input logic [4:0] sh);
      logic [63:0] prod;
      prod = {32'b0, rb} << sh;
      return (s == 3'd4) && (prod >= 64'h1_0000_0000);
   endfunction

   // Drives one cycle, checks outputs mid-cycle, then advances the scoreboard
   task automatic applyStimulus(input logic iv, input logic [31:0] rb, input logic [20:0] imm,
                                input logic [2:0] s, input logic ordy, input logic we,
                                input logic [4:0] sd, input logic fl);
      logic      expValid, expInReady;
      expEntry_t e;
      in_valid  = iv;
      RB        = rb;
      I         = imm;
      S         = s;
      out_ready = ordy;
      sar_we    = we;
      sar_d     = sd;
      flush     = fl;
      @(negedge clk);
      expValid   = (expQ.size() > 0) && (cycleNum >= expQ[0].stamp + 2);
      expInReady = (expQ.size() < 2) || ordy;
      checkOutput("in_ready", {63'b0, in_ready}, {63'b0, expInReady});
      checkOutput("out_valid", {63'b0, out_valid}, {63'b0, expValid});
      checkOutput("sar_q", {59'b0, sar_q}, {59'b0, modelSar});
      if (expValid) begin
         checkOutput("N", {32'b0, N}, {32'b0, expQ[0].n});
`ifdef SHIFT_OVF_FLAG_EN
         checkOutput("out_ovf", {63'b0, out_ovf}, {63'b0, expQ[0].ovf});
`endif
      end
      if (expValid && ordy) begin
         lastOutN = N;
         void'(expQ.pop_front());
      end
      if (iv && expInReady && !fl) begin
         e.n     = modelN(rb, imm, s, modelSar);
         e.ovf   = modelOvf(rb, s, modelSar);
         e.stamp = cycleNum;
         expQ.push_back(e);
      end
      if (fl) expQ.delete();
      if (we) modelSar = sd;
      cycleNum++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 21'h0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      cycleNum   = 0;
      modelSar   = 5'd0;
      lastOutN   = 32'h0;
      reset      = 1'b1;
      flush      = 1'b0;
      sar_we     = 1'b0;
      sar_d      = 5'd0;
      in_valid   = 1'b0;
      RB         = 32'h0;
      I          = 21'h0;
      S          = 3'd0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
      checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("rst_N", {32'b0, N}, 64'd0);
      checkOutput("rst_sar_q", {59'b0, sar_q}, 64'd0);
      reset = 1'b0;

      $display("[TB] single pass-through op");
      applyStimulus(1'b1, 32'h8431FFEB, 21'h0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t1_N", {32'b0, lastOutN}, {32'b0, 32'h8431FFEB});

      $display("[TB] immediate modes back-to-back");
      for (int m = 1; m <= 3; m++)
         applyStimulus(1'b1, 32'h0, 21'h041D61, 3'(m), 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t2_sext5", {32'b0, lastOutN}, {32'b0, 32'h00000001});

      $display("[TB] SAR write on accept");
      applyStimulus(1'b1, 32'h80000001, 21'h0, 3'd6, 1'b1, 1'b1, 5'd4, 1'b0);
      applyStimulus(1'b1, 32'h80000001, 21'h0, 3'd6, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t3_sra", {32'b0, lastOutN}, {32'b0, 32'hF8000000});

      $display("[TB] extract");
      applyStimulus(1'b0, 32'h0, 21'h0, 3'd0, 1'b1, 1'b1, 5'd8, 1'b0);
      applyStimulus(1'b1, 32'h12345678, 21'd7, 3'd7, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t4_ext8", {32'b0, lastOutN}, {32'b0, 32'h00000056});
      applyStimulus(1'b1, 32'h12345678, 21'd31, 3'd7, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t4_ext32", {32'b0, lastOutN}, {32'b0, 32'h00123456});

      $display("[TB] back-pressure");
      applyStimulus(1'b1, 32'h11111111, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'h22222222, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int k = 0; k < 3; k++)
         applyStimulus(1'b1, 32'h33333333, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'h33333333, 21'h0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(3);
      checkOutput("t5_last", {32'b0, lastOutN}, {32'b0, 32'h33333333});

      $display("[TB] flush with both stages full");
      applyStimulus(1'b1, 32'hAAAA5555, 21'h0, 3'd5, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'h5555AAAA, 21'h0, 3'd4, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'hDEADBEEF, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      applyStimulus(1'b0, 32'h0, 21'h0, 3'd0, 1'b1, 1'b1, 5'd1, 1'b1);
      idle(2);

      $display("[TB] left shift losing the sign bit");
      applyStimulus(1'b1, 32'h80000000, 21'h0, 3'd4, 1'b1, 1'b0, 5'd0, 1'b0);
      idle(2);
      checkOutput("t6_shl", {32'b0, lastOutN}, 64'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 32'h01234567, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 32'h89ABCDEF, 21'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("mid_rst_sar_q", {59'b0, sar_q}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      expQ.delete();
      modelSar = 5'd0;
      idle(3);

      $display("[TB] random traffic");
      for (int k = 0; k < 500; k++) begin
         applyStimulus(($urandom_range(0, 9) < 7), $urandom(), 21'($urandom()), 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 5) == 0),
                       5'($urandom_range(0, 31)), ($urandom_range(0, 24) == 0));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
